// File: rtl/spi_burst_ram_pkg.sv
// Shared opcode encodings and frame-width helper for the SPI burst RAM slice.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // A frame carries the 2-bit opcode above the payload.
  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_burst_ram_if.sv
// Frame/response bundle between the SPI slave front end and the burst RAM.
interface spi_burst_ram_if #(
  parameter int DATA_W = 8
) ();
  import spi_ram_pkg::*;

  logic [frame_w(DATA_W)-1:0] din;
  logic                       rx_valid;
  logic [DATA_W-1:0]          dout;
  logic                       tx_valid;
  logic                       wrap;
  logic                       wrap_clr;

  modport master (
    output din, rx_valid, wrap_clr,
    input  dout, tx_valid, wrap
  );

  modport slave (
    input  din, rx_valid, wrap_clr,
    output dout, tx_valid, wrap
  );
endinterface

// File: rtl/spi_burst_ram_array.sv
// Single-port-style storage: one write port, one enabled registered read port.
// Out-of-range addresses drop writes and read back as zero.
module sp_ram_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_ok;
  logic              r_ok;

  assign w_ok = ({1'b0, waddr_i} < DEPTH_L);
  assign r_ok = ({1'b0, raddr_i} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (we_i && w_ok) begin
      mem[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= r_ok ? mem[raddr_i[IDX_W-1:0]] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_burst_ram.sv
// Command-decoding burst RAM: shift-loaded write/read pointers with optional
// post-increment, registered read data with a one-cycle tx_valid pulse.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input logic            clk,
  input logic            rst_n,
  spi_burst_ram_if.slave bus
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MEM_DEPTH - 1);

  logic [1:0]        op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              tx_valid_q, tx_valid_d;
  logic              wrap_q, wrap_d;
  logic              wrap_set;
  logic              wr_wrap, rd_wrap;
  logic              we, re;
  logic [DATA_W-1:0] rdata;

  assign op      = bus.din[DATA_W+1:DATA_W];
  assign payload = bus.din[DATA_W-1:0];

  // MSB-first shift: the old pointer moves up by one payload width.
  function automatic logic [ADDR_W-1:0] shift_load(input logic [ADDR_W-1:0] p,
                                                   input logic [DATA_W-1:0] pl);
    logic [ADDR_W+DATA_W-1:0] cat;
    cat = {p, pl};
    return cat[ADDR_W-1:0];
  endfunction

  // Returns {wrapped, next}; anything at or past the last word wraps to 0.
  function automatic logic [ADDR_W:0] advance(input logic [ADDR_W-1:0] p);
    if (AUTO_INC == 0) begin
      return {1'b0, p};
    end else if ({1'b0, p} >= LAST) begin
      return {1'b1, {ADDR_W{1'b0}}};
    end else begin
      return {1'b0, p + 1'b1};
    end
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_valid_d = 1'b0;
    wr_wrap    = 1'b0;
    rd_wrap    = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    if (bus.rx_valid) begin
      case (op)
        OP_WR_ADDR: wr_ptr_d = shift_load(wr_ptr_q, payload);
        OP_WR_DATA: begin
          we = 1'b1;
          {wr_wrap, wr_ptr_d} = advance(wr_ptr_q);
        end
        OP_RD_ADDR: rd_ptr_d = shift_load(rd_ptr_q, payload);
        OP_RD_DATA: begin
          re         = 1'b1;
          tx_valid_d = 1'b1;
          {rd_wrap, rd_ptr_d} = advance(rd_ptr_q);
        end
        default: ;
      endcase
    end
    wrap_set = wr_wrap | rd_wrap;
    // A new wrap event takes priority over a simultaneous clear.
    wrap_d = wrap_set ? 1'b1 : (bus.wrap_clr ? 1'b0 : wrap_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_valid_q <= tx_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  sp_ram_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(payload),
    .re_i   (re),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign bus.dout     = rdata;
  assign bus.tx_valid = tx_valid_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: default, 12-bit address, and
// no-increment/short-depth configurations side by side.
module tb_spi_burst_ram;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_burst_ram_if #(.DATA_W(8)) if0 ();
  spi_burst_ram_if #(.DATA_W(8)) if1 ();
  spi_burst_ram_if #(.DATA_W(8)) if2 ();

  spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  spi_burst_ram #(.DATA_W(8), .ADDR_W(12), .MEM_DEPTH(4096), .AUTO_INC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One frame: driven on the falling edge, sampled on the next rising edge.
  task automatic send(input int d, input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    case (d)
      0: begin if0.din = {op, pl}; if0.rx_valid = 1'b1; end
      1: begin if1.din = {op, pl}; if1.rx_valid = 1'b1; end
      default: begin if2.din = {op, pl}; if2.rx_valid = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    if0.rx_valid = 1'b0;
    if1.rx_valid = 1'b0;
    if2.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    if0.din = '0; if0.rx_valid = 1'b0; if0.wrap_clr = 1'b0;
    if1.din = '0; if1.rx_valid = 1'b0; if1.wrap_clr = 1'b0;
    if2.din = '0; if2.rx_valid = 1'b0; if2.wrap_clr = 1'b0;
    idle(3);
    check_eq("rst dout0", 32'(if0.dout), 32'h0);
    check_eq("rst tx0", 32'(if0.tx_valid), 32'h0);
    check_eq("rst wrap0", 32'(if0.wrap), 32'h0);
    check_eq("rst tx1", 32'(if1.tx_valid), 32'h0);
    check_eq("rst dout2", 32'(if2.dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic burst write then burst read
    send(0, OP_WR_ADDR, 8'h10);
    send(0, OP_WR_DATA, 8'hAA);
    send(0, OP_WR_DATA, 8'hBB);
    send(0, OP_RD_ADDR, 8'h10);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("burst rd0 dout", 32'(if0.dout), 32'hAA);
    check_eq("burst rd0 tx", 32'(if0.tx_valid), 32'h1);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("burst rd1 dout", 32'(if0.dout), 32'hBB);
    check_eq("burst rd1 tx", 32'(if0.tx_valid), 32'h1);
    check_eq("burst wrap", 32'(if0.wrap), 32'h0);
    idle(1);
    check_eq("burst tx drop", 32'(if0.tx_valid), 32'h0);
    check_eq("burst dout hold", 32'(if0.dout), 32'hBB);

    // Read opcode present but rx_valid low: nothing happens
    if0.din = {OP_RD_DATA, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_eq($sformatf("novalid%0d tx", i), 32'(if0.tx_valid), 32'h0);
      check_eq($sformatf("novalid%0d dout", i), 32'(if0.dout), 32'hBB);
    end

    // Wrap-around on both pointers
    send(0, OP_WR_ADDR, 8'hFF);
    check_eq("wrap before", 32'(if0.wrap), 32'h0);
    send(0, OP_WR_DATA, 8'h55);
    check_eq("wrap after wr", 32'(if0.wrap), 32'h1);
    send(0, OP_WR_DATA, 8'h66);
    send(0, OP_RD_ADDR, 8'hFF);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("wrap rd ff", 32'(if0.dout), 32'h55);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("wrap rd 00", 32'(if0.dout), 32'h66);
    @(negedge clk);
    if0.wrap_clr = 1'b1;
    @(posedge clk);
    #1;
    if0.wrap_clr = 1'b0;
    check_eq("wrap clr", 32'(if0.wrap), 32'h0);
    send(0, OP_RD_ADDR, 8'hFF);
    if0.wrap_clr = 1'b1;
    send(0, OP_RD_DATA, 8'h00);
    if0.wrap_clr = 1'b0;
    check_eq("set beats clr", 32'(if0.wrap), 32'h1);
    check_eq("set beats clr dout", 32'(if0.dout), 32'h55);

    // Wide address loaded over two frames
    send(1, OP_WR_ADDR, 8'h0A);
    send(1, OP_WR_ADDR, 8'hBC);
    send(1, OP_WR_DATA, 8'h3C);
    send(1, OP_WR_DATA, 8'h3D);
    send(1, OP_RD_ADDR, 8'h0A);
    send(1, OP_RD_ADDR, 8'hBC);
    send(1, OP_RD_DATA, 8'h00);
    check_eq("a12 rd abc", 32'(if1.dout), 32'h3C);
    check_eq("a12 tx", 32'(if1.tx_valid), 32'h1);
    send(1, OP_RD_DATA, 8'h00);
    check_eq("a12 rd abd", 32'(if1.dout), 32'h3D);

    // No auto-increment, then an out-of-range address
    send(2, OP_WR_ADDR, 8'h05);
    send(2, OP_WR_DATA, 8'h11);
    send(2, OP_WR_DATA, 8'h22);
    send(2, OP_RD_ADDR, 8'h05);
    send(2, OP_RD_DATA, 8'h00);
    check_eq("noinc rd0", 32'(if2.dout), 32'h22);
    send(2, OP_RD_DATA, 8'h00);
    check_eq("noinc rd1", 32'(if2.dout), 32'h22);
    check_eq("noinc wrap", 32'(if2.wrap), 32'h0);
    send(2, OP_WR_ADDR, 8'hF0);
    send(2, OP_WR_DATA, 8'h77);
    send(2, OP_RD_ADDR, 8'hF0);
    send(2, OP_RD_DATA, 8'h00);
    check_eq("oor rd", 32'(if2.dout), 32'h0);
    check_eq("oor tx", 32'(if2.tx_valid), 32'h1);
    send(2, OP_RD_ADDR, 8'h05);
    send(2, OP_RD_DATA, 8'h00);
    check_eq("oor no alias", 32'(if2.dout), 32'h22);

    // Reset in the middle of a burst
    send(0, OP_WR_ADDR, 8'h20);
    send(0, OP_WR_DATA, 8'hC1);
    send(0, OP_WR_DATA, 8'hC2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst dout", 32'(if0.dout), 32'h0);
    check_eq("midrst wrap", 32'(if0.wrap), 32'h0);
    check_eq("midrst tx", 32'(if0.tx_valid), 32'h0);
    rst_n = 1'b1;
    send(0, OP_RD_DATA, 8'h00);
    check_eq("midrst rd ptr0", 32'(if0.dout), 32'h66);
    send(0, OP_WR_DATA, 8'hD0);
    send(0, OP_RD_ADDR, 8'h20);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("midrst keep 20", 32'(if0.dout), 32'hC1);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("midrst keep 21", 32'(if0.dout), 32'hC2);
    send(0, OP_RD_ADDR, 8'h00);
    send(0, OP_RD_DATA, 8'h00);
    check_eq("midrst wr ptr0", 32'(if0.dout), 32'hD0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
